// File: rtl/seq_arith_pkg.sv
// rtl/seq_arith_pkg.sv - shared types and iteration-count helper for seq_arith_unit
package seq_arith_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIV  = 2'b01,
        OP_SQRT = 2'b10,
        OP_ILL  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    // SQRT retires two radicand bits per iteration, MUL/DIV one bit
    function automatic int unsigned iter_count(input op_e op, input int unsigned width);
        return (op == OP_SQRT) ? (width / 2) : width;
    endfunction

endpackage

// File: rtl/arith_addsub.sv
// rtl/arith_addsub.sv - shared add/subtract unit, sum = a + (sub ? ~b : b) + sub
module arith_addsub #(
    parameter int W = 18
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum
);

    assign sum = a + (sub ? ~b : b) + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/seq_arith_unit.sv
// rtl/seq_arith_unit.sv - iterative signed MUL / unsigned DIV / unsigned SQRT on one shared adder
module seq_arith_unit
    import seq_arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_x,
    input  logic [WIDTH-1:0] data_y,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] residue,
    output logic             error
);

    localparam int AW = WIDTH + 2;
    localparam int HW = WIDTH / 2;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             qm1_q, qm1_d;
    logic [HW-1:0]    root_q, root_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] residue_q, residue_d;
    logic             error_q, error_d;

    logic [AW-1:0]    add_a, add_b, add_sum;
    logic             add_sub;
    logic             error_cond;
    logic             sqrt_step;

    arith_addsub #(.W(AW)) u_addsub (
        .a   (add_a),
        .b   (add_b),
        .sub (add_sub),
        .sum (add_sum)
    );

    always_comb begin
        error_cond = 1'b0;
        case (op_q)
            OP_ILL:  error_cond = 1'b1;
            OP_DIV:  error_cond = (y_q == '0);
            OP_SQRT: error_cond = x_q[WIDTH-1];
            default: error_cond = 1'b0;
        endcase
    end

    // The first SQRT digit is taken in CHECK, so the last RUN cycle is free
    // for the negative-remainder correction on the same adder.
    always_comb begin
        add_a     = '0;
        add_b     = '0;
        add_sub   = 1'b0;
        sqrt_step = (op_q == OP_SQRT) &&
                    ((state_q == CHECK) || ((state_q == RUN) && (cnt_q != CNT_W'(1))));
        if ((state_q == RUN) && (op_q == OP_MUL)) begin
            add_a = {hi_q[WIDTH], hi_q};
            case ({lo_q[0], qm1_q})
                2'b01:   add_b = {{2{x_q[WIDTH-1]}}, x_q};
                2'b10: begin
                    add_b   = {{2{x_q[WIDTH-1]}}, x_q};
                    add_sub = 1'b1;
                end
                default: add_b = '0;
            endcase
        end else if ((state_q == RUN) && (op_q == OP_DIV)) begin
            add_a   = {1'b0, hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
            add_b   = {2'b00, y_q};
            add_sub = 1'b1;
        end else if (sqrt_step) begin
            add_a   = {hi_q[WIDTH-1:0], lo_q[WIDTH-1:WIDTH-2]};
            add_b   = {{(AW-HW-2){1'b0}}, root_q, hi_q[WIDTH], 1'b1};
            add_sub = ~hi_q[WIDTH];
        end else if ((state_q == RUN) && (op_q == OP_SQRT)) begin
            add_a = {hi_q[WIDTH], hi_q};
            add_b = {{(AW-HW-1){1'b0}}, root_q, 1'b1};
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        x_d       = x_q;
        y_d       = y_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        qm1_d     = qm1_q;
        root_d    = root_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        residue_d = residue_q;
        error_d   = error_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CHECK;
                    op_d    = op_e'(op);
                    x_d     = data_x;
                    y_d     = data_y;
                    hi_d    = '0;
                    qm1_d   = 1'b0;
                    root_d  = '0;
                    lo_d    = (op_e'(op) == OP_MUL) ? data_y : data_x;
                end
            end
            CHECK: begin
                if (error_cond) begin
                    state_d   = DONE;
                    result_d  = '0;
                    residue_d = '0;
                    error_d   = 1'b1;
                end else begin
                    state_d = RUN;
                    cnt_d   = CNT_W'(iter_count(op_q, WIDTH));
                    if (sqrt_step) begin
                        hi_d   = add_sum[WIDTH:0];
                        lo_d   = {lo_q[WIDTH-3:0], 2'b00};
                        root_d = {root_q[HW-2:0], ~add_sum[AW-1]};
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - 1'b1;
                case (op_q)
                    OP_MUL: begin
                        hi_d  = {add_sum[WIDTH], add_sum[WIDTH:1]};
                        lo_d  = {add_sum[0], lo_q[WIDTH-1:1]};
                        qm1_d = lo_q[0];
                    end
                    OP_DIV: begin
                        hi_d = add_sum[AW-1] ? {hi_q[WIDTH-1:0], lo_q[WIDTH-1]} : add_sum[WIDTH:0];
                        lo_d = {lo_q[WIDTH-2:0], ~add_sum[AW-1]};
                    end
                    default: begin
                        if (sqrt_step) begin
                            hi_d   = add_sum[WIDTH:0];
                            lo_d   = {lo_q[WIDTH-3:0], 2'b00};
                            root_d = {root_q[HW-2:0], ~add_sum[AW-1]};
                        end else if (hi_q[WIDTH]) begin
                            hi_d = add_sum[WIDTH:0];
                        end
                    end
                endcase
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    error_d = 1'b0;
                    if (op_q == OP_SQRT) begin
                        result_d  = {{(WIDTH-HW){1'b0}}, root_d};
                        residue_d = {{(WIDTH-HW-1){1'b0}}, hi_d[HW:0]};
                    end else begin
                        result_d  = lo_d;
                        residue_d = hi_d[WIDTH-1:0];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            op_q      <= OP_MUL;
            x_q       <= '0;
            y_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            qm1_q     <= 1'b0;
            root_q    <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            residue_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            x_q       <= x_d;
            y_q       <= y_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            qm1_q     <= qm1_d;
            root_q    <= root_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            residue_q <= residue_d;
            error_q   <= error_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign ready   = (state_q == DONE);
    assign result  = result_q;
    assign residue = residue_q;
    assign error   = error_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// tb/tb_seq_arith_unit.sv - directed self-checking bench for seq_arith_unit (16-bit and 8-bit builds)
module tb_seq_arith_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] data_x = '0;
    logic [15:0] data_y = '0;
    logic        busy, ready, error;
    logic [15:0] result, residue;

    logic        start8 = 1'b0;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  x8 = '0;
    logic [7:0]  y8 = '0;
    logic        busy8, ready8, error8;
    logic [7:0]  result8, residue8;

    int n_cmp = 0;
    int n_bad = 0;

    int          r1_cyc, r2_cyc, nready, busy_cnt, idle_cyc;
    logic [15:0] r1_res, r1_rsd, r2_res, r2_rsd;
    logic        r1_err, r2_err;

    always #5 clk = ~clk;

    seq_arith_unit #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .data_x(data_x), .data_y(data_y),
        .busy(busy), .ready(ready), .result(result), .residue(residue), .error(error)
    );

    seq_arith_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .data_x(x8), .data_y(y8),
        .busy(busy8), .ready(ready8), .result(result8), .residue(residue8), .error(error8)
    );

    // Issue one request, then present (o2,x2,y2) on the inputs and pulse start in cycles pa/pb.
    task automatic do_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic [1:0] o2, input logic [15:0] x2, input logic [15:0] y2,
                         input int pa, input int pb, input int win);
        r1_cyc = 0; r2_cyc = 0; nready = 0; busy_cnt = 0; idle_cyc = 0;
        r1_res = '0; r1_rsd = '0; r2_res = '0; r2_rsd = '0; r1_err = 1'b0; r2_err = 1'b0;
        @(negedge clk);
        start = 1'b1; op = o; data_x = x; data_y = y;
        @(posedge clk);
        #1;
        start = 1'b0; op = o2; data_x = x2; data_y = y2;
        for (int k = 1; k <= win; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            else if (idle_cyc == 0) idle_cyc = k;
            if (ready) begin
                nready++;
                if (nready == 1) begin
                    r1_cyc = k; r1_res = result; r1_rsd = residue; r1_err = error;
                end else begin
                    r2_cyc = k; r2_res = residue == residue ? result : result; r2_rsd = residue; r2_err = error;
                end
            end
            start = (k == pa) || (k == pb);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", error); end
        n_cmp++; if (result !== 16'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0000", result); end
        n_cmp++; if (residue !== 16'h0) begin n_bad++; $display("FAIL reset_residue: got %h want 0000", residue); end
        n_cmp++; if ({busy8, result8, residue8} !== 17'h0) begin n_bad++; $display("FAIL reset_w8: got %h want 0", {busy8, result8, residue8}); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_mul();
        do_op(2'b00, 16'hFFF9, 16'h012C, 2'b01, 16'h0000, 16'h0000, 0, 0, 22);
        n_cmp++; if (r1_cyc !== 18) begin n_bad++; $display("FAIL mul_ready_cycle: got %0d want 18", r1_cyc); end
        n_cmp++; if (r1_res !== 16'hF7CC) begin n_bad++; $display("FAIL mul_result: got %h want f7cc", r1_res); end
        n_cmp++; if (r1_rsd !== 16'hFFFF) begin n_bad++; $display("FAIL mul_residue: got %h want ffff", r1_rsd); end
        n_cmp++; if (r1_err !== 1'b0) begin n_bad++; $display("FAIL mul_error: got %b want 0", r1_err); end
        n_cmp++; if (idle_cyc !== 19) begin n_bad++; $display("FAIL mul_busy_fall: got %0d want 19", idle_cyc); end
        n_cmp++; if (nready !== 1) begin n_bad++; $display("FAIL mul_ready_pulses: got %0d want 1", nready); end
    endtask

    task automatic test_div();
        do_op(2'b01, 16'd1000, 16'd7, 2'b11, 16'hFFFF, 16'h0000, 0, 0, 22);
        n_cmp++; if (r1_cyc !== 18) begin n_bad++; $display("FAIL div_ready_cycle: got %0d want 18", r1_cyc); end
        n_cmp++; if (r1_res !== 16'd142) begin n_bad++; $display("FAIL div_quotient: got %0d want 142", r1_res); end
        n_cmp++; if (r1_rsd !== 16'd6) begin n_bad++; $display("FAIL div_remainder: got %0d want 6", r1_rsd); end
        n_cmp++; if (r1_err !== 1'b0) begin n_bad++; $display("FAIL div_error: got %b want 0", r1_err); end
    endtask

    task automatic test_sqrt();
        do_op(2'b10, 16'd1000, 16'h1234, 2'b00, 16'h0003, 16'h0003, 0, 0, 14);
        n_cmp++; if (r1_cyc !== 10) begin n_bad++; $display("FAIL sqrt_ready_cycle: got %0d want 10", r1_cyc); end
        n_cmp++; if (r1_res !== 16'd31) begin n_bad++; $display("FAIL sqrt_root: got %0d want 31", r1_res); end
        n_cmp++; if (r1_rsd !== 16'd39) begin n_bad++; $display("FAIL sqrt_residue: got %0d want 39", r1_rsd); end
        do_op(2'b10, 16'hFFFF >> 2, 16'h0000, 2'b00, 16'h0, 16'h0, 0, 0, 14);
        n_cmp++; if (r1_res !== 16'd127) begin n_bad++; $display("FAIL sqrt_3fff_root: got %0d want 127", r1_res); end
        n_cmp++; if (r1_rsd !== 16'd254) begin n_bad++; $display("FAIL sqrt_3fff_residue: got %0d want 254", r1_rsd); end
        do_op(2'b10, 16'h8000, 16'h0000, 2'b00, 16'h0, 16'h0, 0, 0, 6);
        n_cmp++; if (r1_cyc !== 2) begin n_bad++; $display("FAIL sqrt_neg_ready_cycle: got %0d want 2", r1_cyc); end
        n_cmp++; if (r1_err !== 1'b1) begin n_bad++; $display("FAIL sqrt_neg_error: got %b want 1", r1_err); end
        n_cmp++; if ({r1_res, r1_rsd} !== 32'h0) begin n_bad++; $display("FAIL sqrt_neg_outputs: got %h want 0", {r1_res, r1_rsd}); end
    endtask

    task automatic test_errors();
        do_op(2'b01, 16'd55, 16'd0, 2'b00, 16'h0, 16'h0, 0, 0, 6);
        n_cmp++; if (r1_cyc !== 2) begin n_bad++; $display("FAIL div0_ready_cycle: got %0d want 2", r1_cyc); end
        n_cmp++; if (r1_err !== 1'b1) begin n_bad++; $display("FAIL div0_error: got %b want 1", r1_err); end
        n_cmp++; if (busy_cnt !== 2) begin n_bad++; $display("FAIL div0_busy_cycles: got %0d want 2", busy_cnt); end
        n_cmp++; if ({r1_res, r1_rsd} !== 32'h0) begin n_bad++; $display("FAIL div0_outputs: got %h want 0", {r1_res, r1_rsd}); end
        do_op(2'b11, 16'd9, 16'd9, 2'b00, 16'h0, 16'h0, 0, 0, 6);
        n_cmp++; if (r1_cyc !== 2) begin n_bad++; $display("FAIL ill_ready_cycle: got %0d want 2", r1_cyc); end
        n_cmp++; if (r1_err !== 1'b1) begin n_bad++; $display("FAIL ill_error: got %b want 1", r1_err); end
        n_cmp++; if (busy_cnt !== 2) begin n_bad++; $display("FAIL ill_busy_cycles: got %0d want 2", busy_cnt); end
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL ill_error_hold: got %b want 1", error); end
        do_op(2'b00, 16'd3, 16'd4, 2'b11, 16'h0, 16'h0, 0, 0, 22);
        n_cmp++; if (r1_cyc !== 18) begin n_bad++; $display("FAIL mul34_ready_cycle: got %0d want 18", r1_cyc); end
        n_cmp++; if (r1_err !== 1'b0) begin n_bad++; $display("FAIL mul34_error: got %b want 0", r1_err); end
        n_cmp++; if (r1_res !== 16'd12) begin n_bad++; $display("FAIL mul34_result: got %0d want 12", r1_res); end
        n_cmp++; if (r1_rsd !== 16'd0) begin n_bad++; $display("FAIL mul34_residue: got %0d want 0", r1_rsd); end
    endtask

    task automatic test_start_ignored();
        do_op(2'b01, 16'd1000, 16'd7, 2'b00, 16'd5, 16'd5, 3, 5, 26);
        n_cmp++; if (nready !== 1) begin n_bad++; $display("FAIL ignore_ready_pulses: got %0d want 1", nready); end
        n_cmp++; if (r1_cyc !== 18) begin n_bad++; $display("FAIL ignore_ready_cycle: got %0d want 18", r1_cyc); end
        n_cmp++; if (r1_res !== 16'd142) begin n_bad++; $display("FAIL ignore_quotient: got %0d want 142", r1_res); end
        n_cmp++; if (busy_cnt !== 18) begin n_bad++; $display("FAIL ignore_busy_cycles: got %0d want 18", busy_cnt); end
    endtask

    task automatic test_back_to_back();
        do_op(2'b00, 16'hFFF9, 16'h012C, 2'b01, 16'd1000, 16'd7, 19, 0, 40);
        n_cmp++; if (r1_cyc !== 18) begin n_bad++; $display("FAIL b2b_first_cycle: got %0d want 18", r1_cyc); end
        n_cmp++; if (r1_res !== 16'hF7CC) begin n_bad++; $display("FAIL b2b_first_result: got %h want f7cc", r1_res); end
        n_cmp++; if (r2_cyc !== 37) begin n_bad++; $display("FAIL b2b_second_cycle: got %0d want 37", r2_cyc); end
        n_cmp++; if (r2_res !== 16'd142) begin n_bad++; $display("FAIL b2b_second_result: got %0d want 142", r2_res); end
        n_cmp++; if (r2_rsd !== 16'd6) begin n_bad++; $display("FAIL b2b_second_residue: got %0d want 6", r2_rsd); end
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        @(negedge clk);
        start = 1'b1; op = 2'b01; data_x = 16'd60000; data_y = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before: got %b want 1", busy); end
        n_cmp++; if (result !== 16'd142) begin n_bad++; $display("FAIL abort_result_before: got %0d want 142", result); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL abort_ready: got %b want 0", ready); end
        n_cmp++; if (result !== 16'h0) begin n_bad++; $display("FAIL abort_result: got %h want 0000", result); end
        n_cmp++; if (residue !== 16'h0) begin n_bad++; $display("FAIL abort_residue: got %h want 0000", residue); end
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (ready || busy) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL abort_no_ready: got %0d active cycles want 0", pulses); end
    endtask

    task automatic test_w8();
        int          cyc;
        logic [7:0]  res, rsd;
        logic        err;
        cyc = 0; res = '0; rsd = '0; err = 1'b1;
        @(negedge clk);
        start8 = 1'b1; op8 = 2'b00; x8 = 8'd12; y8 = 8'hFD;
        @(posedge clk);
        #1;
        start8 = 1'b0; x8 = 8'h00; y8 = 8'h00;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (ready8 && cyc == 0) begin
                cyc = k; res = result8; rsd = residue8; err = error8;
            end
        end
        n_cmp++; if (cyc !== 10) begin n_bad++; $display("FAIL w8_ready_cycle: got %0d want 10", cyc); end
        n_cmp++; if (res !== 8'hDC) begin n_bad++; $display("FAIL w8_result: got %h want dc", res); end
        n_cmp++; if (rsd !== 8'hFF) begin n_bad++; $display("FAIL w8_residue: got %h want ff", rsd); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL w8_error: got %b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_sqrt();
        test_errors();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_w8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_arith_unit.md
Name: seq_arith_unit

Overview:
Parametrised sequential arithmetic core that performs signed multiply, unsigned divide or unsigned square root on WIDTH-bit operands.
- One shared add/subtract datapath, one iteration per clock, start/ready handshake.
- Built-in operand validation: an invalid operand or op raises error with no iterations run.
- Sits between the operand registers and the result register / BCD display path, and replaces the separate per-operation engines and muxes.

Parameters:
WIDTH, 16, operand and result width; even, >= 4
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, do not override)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
op  in  2  00 MUL, 01 DIV, 10 SQRT, 11 illegal
data_x  in  WIDTH  multiplicand / dividend / radicand
data_y  in  WIDTH  multiplier / divisor; ignored for SQRT
busy  out  1  high whenever state != IDLE
ready  out  1  one-cycle pulse, high during DONE
result  out  WIDTH  product low word / quotient / root (zero-extended)
residue  out  WIDTH  product high word / remainder / sqrt remainder (zero-extended)
error  out  1  operation rejected; valid alongside ready

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low. While rst=0: state IDLE; busy, ready, error = 0; result, residue, counter and working registers = 0.
- Reset mid-operation aborts immediately. No ready pulse follows.
- States and transitions:
  - IDLE: if start=1 at an edge, latch op, data_x and data_y, then go to CHECK. Otherwise stay.
  - CHECK (1 cycle): error_cond is true for any of: op=11; op=DIV with data_y=0; op=SQRT with data_x[WIDTH-1]=1. If error_cond, go to DONE with the error flag set. Otherwise load the counter with N and go to RUN. N is WIDTH for MUL/DIV and WIDTH/2 for SQRT.
  - RUN: one iteration per cycle. The counter decrements each cycle. On the cycle the counter reaches 1, go to DONE.
  - DONE (1 cycle): ready=1. Register result, residue and error, then go to IDLE.
- Latency, counted from the edge that samples start: ready is high in cycle N+2. On the error path it is high in cycle 2.
- Hold rules:
  - result, residue and error hold their values until the next DONE.
  - On the error path, result and residue are 0 and error is 1.
  - On the success path, error is 0.
- start is ignored while busy=1. Back-to-back requests are allowed: start may be high in the IDLE cycle immediately after DONE.
- MUL: radix-2 Booth, signed two's complement. Accumulator holds 2*WIDTH+1 bits. Each iteration inspects the {q0,q-1} pair, adds or subtracts the multiplicand via the shared adder, then shifts right arithmetically. Output: result = prod[WIDTH-1:0], residue = prod[2*WIDTH-1:WIDTH].
- DIV: restoring, unsigned. Each iteration shifts the partial remainder left, trial-subtracts the divisor via the shared adder, and restores if negative. Output: quotient and remainder.
- SQRT: non-restoring digit-by-digit, unsigned, two radicand bits per iteration. Output: root = floor(sqrt(data_x)) and residue = data_x - root^2. Both fit in WIDTH/2+1 bits and are zero-extended.
- Shared adder: a single WIDTH+2-bit add/subtract unit, muxed by the latched op. Only one operation is ever in flight.
- Changes to data_x, data_y or op after the sampling edge have no effect on the running operation.

Decomposition:
- Package seq_arith_pkg holds:
  - op_e enum: OP_MUL=2'b00, OP_DIV=2'b01, OP_SQRT=2'b10, OP_ILL=2'b11
  - state_e enum: IDLE, CHECK, RUN, DONE
  - a function iter_count(op, WIDTH) that returns N
- Sub-module arith_addsub, parametrised by width: inputs a, b, sub; output sum = a + (sub ? ~b : b) + sub. Instantiated once.

Test Plan:
- WIDTH=16, MUL, x=0xFFF9 (-7), y=0x012C (300) -> ready in cycle 18; result=0xF7CC, residue=0xFFFF, error=0, busy falls in cycle 19.
- WIDTH=16, DIV, x=1000, y=7 -> ready in cycle 18; result=142, residue=6, error=0.
- WIDTH=16, SQRT, x=1000 -> ready in cycle 10; result=31, residue=39. Then x=0x8000 -> ready in cycle 2 with error=1, result=0, residue=0.
- Error paths: DIV with y=0, and op=11 -> each gives ready in cycle 2, error=1, and no RUN cycles (busy high for exactly 2 cycles). The next valid MUL 3*4 clears error and gives result=12.
- Start pulsed in cycles 3 and 5 during a DIV -> ignored, and exactly one ready pulse occurs. Then rst=0 asserted asynchronously mid-RUN of a second DIV -> busy, ready, result and residue go to 0 without waiting for a clock, and no ready pulse follows.
- WIDTH=8 build, MUL, x=12, y=0xFD (-3) -> ready in cycle 10; result=0xDC, residue=0xFF.
